sprite_rom_arbiter: RTL and testbench
=====================================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one synchronous sprite/tile ROM (e.g. the 32x32 stone tile ROM) between NUM_REQ
//  requesters. Requester 0 is the pixel renderer and has strict priority while video is active;
//  the rest (collision probes, minimap, etc.) are served round-robin. Returns each read
//  ROM_LAT cycles after grant with a one-hot valid, so the ROM sits behind a single mux.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8); index 0 = renderer
//  ADDR_W   10   ROM address width
//  DATA_W    8   ROM word width (palette index)
//  ROM_LAT   1   cycles from rom_address/rom_rd to rom_q valid (1..4)
// PORTS
//  vga_clk     in   1               single clock, all logic on posedge
//  reset       in   1               asynchronous, active-high
//  blank       in   1               1 = active video (display on), 0 = blanking
//  req         in   NUM_REQ         request per requester, held until granted
//  req_addr    in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  gnt         out  NUM_REQ         one-hot (or zero) grant, combinational, same cycle as req
//  rd_valid    out  NUM_REQ         one-hot: rd_data belongs to requester i this cycle
//  rd_data     out  DATA_W          = rom_q (shared return bus)
//  rom_rd      out  1               ROM read strobe (= |gnt)
//  rom_address out  ADDR_W          address of granted requester, 0 when idle
//  rom_q       in   DATA_W          ROM output, valid ROM_LAT cycles after rom_rd
// BEHAVIOUR
//  - Reset (async assert, sync release): tag pipeline cleared (rd_valid=0), rr_ptr=1;
//    with req=0, gnt=0, rom_rd=0, rom_address=0. In-flight reads are dropped, never returned.
//  - One grant per cycle max; gnt[i] only if req[i]. Requester samples gnt at posedge
//    and may drop req / change address the following cycle. No grant while reset high.
//  - Priority, blank=1: req[0] wins unconditionally; else round-robin over 1..NUM_REQ-1.
//  - Priority, blank=0: round-robin over all 0..NUM_REQ-1 (renderer gets no preference).
//  - Round-robin: search starts at rr_ptr, wraps NUM_REQ-1 -> 0 (skips 0 when blank=1).
//    After a round-robin grant to k, rr_ptr <= (k+1) mod NUM_REQ. A strict-priority grant
//    to 0 does NOT move rr_ptr. No grant -> rr_ptr holds.
//  - rom_address = req_addr slice of winner; rom_rd = |gnt.
//  - Return: tag pipeline ROM_LAT deep carries {valid, id}; rd_valid[id] asserted exactly
//    ROM_LAT cycles after gnt[id], for one cycle per grant. Back-to-back grants stream
//    one result per cycle, order preserved. rd_data = rom_q always (unqualified otherwise).
//  - blank toggling between grants affects only the next arbitration; in-flight reads
//    complete normally.
//  - Starvation: requesters 1..N-1 may wait a full active line if renderer requests every
//    cycle; bounded by next blanking interval, within which every pending request is served
//    within NUM_REQ cycles.
// TESTING
//  1 Reset: reset=1 with all req=1 -> gnt=0, rd_valid=0; release -> first blank=0 grant
//    is requester 1 (rr_ptr=1).
//  2 blank=1, req=4'b1111 for 6 cycles -> gnt=4'b0001 every cycle, rr_ptr stays 1;
//    rd_valid[0] each cycle from cycle ROM_LAT, rd_data = ROM[addr0].
//  3 blank=0, req=4'b1111 held -> gnt sequence 1,2,3,0,1,... ; rd_valid follows same
//    sequence delayed ROM_LAT; data matches ROM model at each address.
//  4 blank=1, req=4'b1010, req[0] pulsing every other cycle -> 0 granted when asserted,
//    1 and 3 alternate in gaps; no requester >3 gaps without grant.
//  5 ROM_LAT=3: grant to 2 then assert reset one cycle later -> no rd_valid emitted for
//    that read after reset; rr_ptr=1 after release.
//  6 Single requester 3, addr=10'h3FF -> rom_address=10'h3FF, rd_valid=4'b1000 at +ROM_LAT.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter.
//   req       requester -> arbiter  one request bit per requester, held until granted
//   req_addr  requester -> arbiter  packed ROM addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       arbiter -> requester  one-hot (or zero) grant, same cycle as req
//   rd_valid  arbiter -> requester  one-hot owner of rd_data this cycle
//   rd_data   arbiter -> requester  shared ROM return bus
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        output req,
        output req_addr,
        input  gnt,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  req,
        input  req_addr,
        output gnt,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite/tile ROM between NUM_REQ requesters.
// Requester 0 (renderer) has strict priority during active video (blank=1);
// otherwise all eligible requesters are served round-robin. Each read returns
// ROM_LAT cycles after its grant with a one-hot rd_valid on the shared bus.
//   vga_clk      clock, all logic on posedge
//   reset        asynchronous, active-high
//   blank        1 = active video, 0 = blanking
//   bus          requester interface (slave side): req/req_addr in, gnt/rd_valid/rd_data out
//   rom_rd       ROM read strobe (= |gnt)
//   rom_address  address of the granted requester, 0 when idle
//   rom_q        ROM output, valid ROM_LAT cycles after rom_rd
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                        vga_clk,
    input  logic                        reset,
    input  logic                        blank,
    sprite_rom_arbiter_if.slave         bus,
    output logic                        rom_rd,
    output logic [ADDR_W-1:0]           rom_address,
    input  logic [DATA_W-1:0]           rom_q
);

    localparam int unsigned ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic vld;
        id_t  id;
    } tag_t;

    id_t              rr_ptr;
    id_t              rr_ptr_nxt;
    id_t              win_id;
    logic             win_vld;
    logic             win_rr;
    logic [NUM_REQ-1:0] rr_mask;
    tag_t             tag_q [ROM_LAT];

    // (base + off) mod NUM_REQ for a non-power-of-two requester count
    function automatic id_t wrap_add(input id_t base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // Arbitration: strict renderer priority in active video, else round-robin
    always_comb begin
        win_vld    = 1'b0;
        win_id     = '0;
        win_rr     = 1'b0;
        rr_mask    = bus.req;
        rr_ptr_nxt = rr_ptr;
        // the renderer only joins the rotation during blanking
        if (blank) begin
            rr_mask[0] = 1'b0;
        end
        if (!reset) begin
            if (blank && bus.req[0]) begin
                win_vld = 1'b1;
            end else begin
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (!win_vld && rr_mask[wrap_add(rr_ptr, j)]) begin
                        win_vld = 1'b1;
                        win_rr  = 1'b1;
                        win_id  = wrap_add(rr_ptr, j);
                    end
                end
            end
        end
        // strict-priority grants leave the rotation where it was
        if (win_rr) begin
            rr_ptr_nxt = wrap_add(win_id, 1);
        end
    end

    // Grant decode and ROM request mux
    always_comb begin
        bus.gnt     = '0;
        rom_address = '0;
        if (win_vld) begin
            bus.gnt[win_id] = 1'b1;
            rom_address     = bus.req_addr[32'(win_id)*ADDR_W +: ADDR_W];
        end
    end

    assign rom_rd = win_vld;

    // Round-robin pointer
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= ID_W'(1);
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Tag pipeline tracking which requester owns each in-flight ROM read
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: win_vld, id: win_id};
            for (int unsigned k = 1; k < ROM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Return path: oldest tag selects the owner of rom_q
    always_comb begin
        bus.rd_valid = '0;
        if (tag_q[ROM_LAT-1].vld) begin
            bus.rd_valid[tag_q[ROM_LAT-1].id] = 1'b1;
        end
    end

    assign bus.rd_data = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ROM_LAT = 3;

    typedef struct {
        logic       rst;
        logic       blank;
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    logic              vga_clk;
    logic              reset;
    logic              blank;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] rs [ROM_LAT];
    logic [ADDR_W-1:0] addr_tab [NUM_REQ];
    logic [3:0]        g [ROM_LAT];
    vec_t              vecs [$];
    int                n_checks;
    int                n_fail;

    sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .blank      (blank),
        .bus        (bus.slave),
        .rom_rd     (rom_rd),
        .rom_address(rom_address),
        .rom_q      (rom_q)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return 8'(a ^ (a >> 3)) ^ 8'h5A;
    endfunction

    // Synchronous ROM with ROM_LAT cycles of latency
    always @(posedge vga_clk) begin
        rs[0] <= rom_word(rom_address);
        for (int k = 1; k < ROM_LAT; k++) rs[k] <= rs[k-1];
    end
    assign rom_q = rs[ROM_LAT-1];

    assign addr_tab[0] = 10'h0C3;
    assign addr_tab[1] = 10'h15A;
    assign addr_tab[2] = 10'h2A5;
    assign addr_tab[3] = 10'h3FF;
    assign bus.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic [3:0] rq,
                       input logic [3:0] gn, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{rst: r, blank: b, req: rq, gnt: gn});
    endtask

    task automatic apply(input vec_t v, input int row);
        logic [3:0]        exp_rdv;
        logic [ADDR_W-1:0] exp_addr;
        string             tag;
        @(posedge vga_clk);
        #1;
        reset   = v.rst;
        blank   = v.blank;
        bus.req = v.req;
        #3;
        tag      = $sformatf("row%0d", row);
        exp_rdv  = v.rst ? 4'b0000 : g[ROM_LAT-1];
        exp_addr = (v.gnt == 4'b0000) ? '0 : addr_tab[oh_idx(v.gnt)];
        check({tag, " gnt"}, 32'(bus.gnt), 32'(v.gnt));
        check({tag, " rom_rd"}, 32'(rom_rd), 32'(v.gnt != 4'b0000));
        check({tag, " rom_address"}, 32'(rom_address), 32'(exp_addr));
        check({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(exp_rdv));
        if (exp_rdv != 4'b0000)
            check({tag, " rd_data"}, 32'(bus.rd_data), 32'(rom_word(addr_tab[oh_idx(exp_rdv)])));
        if (v.rst) begin
            for (int k = 0; k < ROM_LAT; k++) g[k] = 4'b0000;
        end else begin
            for (int k = ROM_LAT - 1; k > 0; k--) g[k] = g[k-1];
            g[0] = v.gnt;
        end
    endtask

    initial begin
        int lat;
        logic seen;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        blank    = 1'b0;
        bus.req  = 4'b0000;
        for (int k = 0; k < ROM_LAT; k++) g[k] = 4'b0000;

        // reset holds off every grant
        add(1, 0, 4'b1111, 4'b0000, 1);
        add(1, 1, 4'b1111, 4'b0000, 1);
        // active video: renderer wins every cycle, rotation untouched
        add(0, 1, 4'b1111, 4'b0001, 6);
        // blanking: full rotation starting at 1
        add(0, 0, 4'b1111, 4'b0010, 1);
        add(0, 0, 4'b1111, 4'b0100, 1);
        add(0, 0, 4'b1111, 4'b1000, 1);
        add(0, 0, 4'b1111, 4'b0001, 1);
        add(0, 0, 4'b1111, 4'b0010, 1);
        add(0, 0, 4'b1111, 4'b0100, 1);
        // active video, renderer pulsing; 1 and 3 share the gaps
        add(0, 1, 4'b1011, 4'b0001, 1);
        add(0, 1, 4'b1010, 4'b1000, 1);
        add(0, 1, 4'b1011, 4'b0001, 1);
        add(0, 1, 4'b1010, 4'b0010, 1);
        add(0, 1, 4'b1011, 4'b0001, 1);
        add(0, 1, 4'b1010, 4'b1000, 1);
        add(0, 1, 4'b1011, 4'b0001, 1);
        add(0, 1, 4'b1010, 4'b0010, 1);
        // lone requester 3 at the top address
        add(0, 0, 4'b1000, 4'b1000, 1);
        add(0, 0, 4'b0000, 4'b0000, 3);
        // wrap 3 -> 0 in the rotation
        add(0, 0, 4'b0001, 4'b0001, 1);
        add(0, 0, 4'b1001, 4'b1000, 1);
        add(0, 0, 4'b1001, 4'b0001, 1);
        // grant to 2 then reset: read dropped, pointer back to 1
        add(0, 0, 4'b0100, 4'b0100, 1);
        add(1, 0, 4'b0100, 4'b0000, 1);
        add(0, 0, 4'b0000, 4'b0000, 4);
        add(0, 0, 4'b1111, 4'b0010, 1);
        add(0, 0, 4'b0000, 4'b0000, 3);

        foreach (vecs[i]) apply(vecs[i], i);

        // latency of a single renderer read
        @(posedge vga_clk);
        #1;
        blank   = 1'b1;
        bus.req = 4'b0001;
        #3;
        check("lat gnt", 32'(bus.gnt), 32'(4'b0001));
        @(posedge vga_clk);
        #1;
        bus.req = 4'b0000;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            if (c > 1) begin
                @(posedge vga_clk);
                #4;
            end else begin
                #3;
            end
            if (bus.rd_valid != 4'b0000) lat = c;
        end
        check("lat cycles", 32'(lat), 32'(ROM_LAT));
        check("lat rd_valid", 32'(bus.rd_valid), 32'(4'b0001));
        check("lat rd_data", 32'(bus.rd_data), 32'(rom_word(addr_tab[0])));

        // reset pulse mid-cycle while a read is in flight
        @(posedge vga_clk);
        #1;
        bus.req = 4'b0001;
        @(posedge vga_clk);
        #1;
        bus.req = 4'b0000;
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge vga_clk);
            #4;
            if (bus.rd_valid != 4'b0000) seen = 1'b1;
        end
        check("flush rd_valid", 32'(seen), 32'(1'b0));
        @(posedge vga_clk);
        #1;
        blank   = 1'b0;
        bus.req = 4'b1111;
        #3;
        check("post-reset gnt", 32'(bus.gnt), 32'(4'b0010));
        @(posedge vga_clk);
        #1;
        bus.req = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
